// File: rtl/fruit_control.sv
// -----------------------------------------------------------------------------
// fruit_control
//
// Per-fruit game controller. Sits directly upstream of the fruit motion block
// and tells it when to launch a fruit (new_fruit) and when the fruit is in the
// air (move_fruit). Every frame it decides slice hits, misses, lives and game
// over. The score output feeds the motion block's number_of_fruits_cut input.
//
// Ports
//   frame_clk             in   1   frame-rate clock (vsync)
//   Reset_n               in   1   asynchronous active-low reset
//   start                 in   1   level; begins a game from IDLE or GAME_OVER
//   fruitX, fruitY        in  10   fruit centre position
//   fruitS                in  10   fruit half-size
//   bladeX, bladeY        in  10   cursor position
//   blade_active          in   1   mouse button held
//   new_fruit             out  1   one-frame spawn pulse
//   move_fruit            out  1   fruit (or its halves) in flight
//   number_of_fruits_cut  out  8   score, saturating at 255
//   lives                 out  2   remaining lives
//   fruit_visible         out  1   draw the whole fruit
//   fruit_sliced          out  1   draw the split fruit
//   game_over             out  1   high in GAME_OVER
//
// Optional feature macro: FRUIT_CTRL_SPEEDUP_EN
//   When defined, the WAIT length shrinks as the score rises:
//   max(4, SPAWN_DELAY - (score >> 2)) frames, sampled on entry to WAIT.
//   When undefined, WAIT always lasts SPAWN_DELAY frames.
//
// Flag outputs are a registered decode of the current state, so they trail
// the state register by one frame. Lives and score are the state registers
// themselves.
// -----------------------------------------------------------------------------
module fruit_control #(
  parameter int SPAWN_DELAY = 30,
  parameter int ARM_FRAMES  = 8,
  parameter int SLICE_HOLD  = 15,
  parameter int LIVES_INIT  = 3,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic [9:0] fruitX,
  input  logic [9:0] fruitY,
  input  logic [9:0] fruitS,
  input  logic [9:0] bladeX,
  input  logic [9:0] bladeY,
  input  logic       blade_active,
  output logic       new_fruit,
  output logic       move_fruit,
  output logic [7:0] number_of_fruits_cut,
  output logic [1:0] lives,
  output logic       fruit_visible,
  output logic       fruit_sliced,
  output logic       game_over
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT      = 3'd1,
    ST_SPAWN     = 3'd2,
    ST_FLIGHT    = 3'd3,
    ST_SLICED    = 3'd4,
    ST_MISSED    = 3'd5,
    ST_GAME_OVER = 3'd6
  } state_t;

  localparam logic [7:0] SPAWN_LAST  = 8'(SPAWN_DELAY - 1);
  localparam logic [7:0] ARM_COUNT   = 8'(ARM_FRAMES);
  localparam logic [7:0] SLICE_LAST  = 8'(SLICE_HOLD - 1);
  localparam logic [1:0] LIVES_START = 2'(LIVES_INIT);
  localparam logic [9:0] X_LIMIT     = 10'(SCREEN_W);
  localparam logic [9:0] Y_LIMIT     = 10'(SCREEN_H);
  localparam logic [7:0] SCORE_MAX   = 8'hFF;

  // Unsigned |a - b| without needing a wider intermediate.
  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [7:0] score_r, score_s;
  logic [1:0] lives_r, lives_s;
  logic [7:0] wait_last_s;
  logic       hit_s;
  logic       offscreen_s;
  logic       armed_s;

  // The blade hits when it is held inside the fruit's bounding square.
  assign hit_s = blade_active
               && (abs_diff(bladeX, fruitX) <= fruitS)
               && (abs_diff(bladeY, fruitY) <= fruitS);

  // Anything at or beyond the screen edge, including 10-bit underflow wrap.
  assign offscreen_s = (fruitX >= X_LIMIT) || (fruitY >= Y_LIMIT);

  // Miss detection is masked until the counter has saturated.
  assign armed_s = (cnt_r == ARM_COUNT);

`ifdef FRUIT_CTRL_SPEEDUP_EN
  logic [7:0] wait_last_r, wait_last_n;

  // Last WAIT counter value for a given score: max(4, SPAWN_DELAY - score/4) - 1.
  function automatic logic [7:0] wait_last_for(input logic [7:0] score);
    logic [8:0] quarter;
    quarter = {3'b000, score[7:2]};
    if ((quarter + 9'd4) >= 9'(SPAWN_DELAY)) begin
      return 8'd3;
    end else begin
      return SPAWN_LAST - quarter[7:0];
    end
  endfunction

  // Capture the WAIT length from the score that is current when WAIT is entered.
  always_comb begin
    wait_last_n = wait_last_r;
    if ((state_s == ST_WAIT) && (state_r != ST_WAIT)) begin
      wait_last_n = wait_last_for(score_s);
    end else begin
      wait_last_n = wait_last_r;
    end
  end

  // WAIT length register.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_last_r <= SPAWN_LAST;
    end else begin
      wait_last_r <= wait_last_n;
    end
  end

  assign wait_last_s = wait_last_r;
`else
  assign wait_last_s = SPAWN_LAST;
`endif

  // Next-state, counter, score and lives logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    score_s = score_r;
    lives_s = lives_r;
    case (state_r)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          lives_s = LIVES_START;
          score_s = 8'd0;
          cnt_s   = 8'd0;
          state_s = ST_WAIT;
        end else begin
          state_s = state_r;
        end
      end
      ST_WAIT: begin
        if (cnt_r >= wait_last_s) begin
          cnt_s   = 8'd0;
          state_s = ST_SPAWN;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_SPAWN: begin
        cnt_s   = 8'd0;
        state_s = ST_FLIGHT;
      end
      ST_FLIGHT: begin
        // A hit takes priority over a simultaneous off-screen miss.
        if (hit_s) begin
          if (score_r != SCORE_MAX) begin
            score_s = score_r + 8'd1;
          end else begin
            score_s = score_r;
          end
          cnt_s   = 8'd0;
          state_s = ST_SLICED;
        end else if (armed_s && offscreen_s) begin
          cnt_s   = 8'd0;
          state_s = ST_MISSED;
        end else if (!armed_s) begin
          cnt_s = cnt_r + 8'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_SLICED: begin
        if (cnt_r >= SLICE_LAST) begin
          cnt_s   = 8'd0;
          state_s = ST_WAIT;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_MISSED: begin
        cnt_s = 8'd0;
        if (lives_r > 2'd1) begin
          lives_s = lives_r - 2'd1;
          state_s = ST_WAIT;
        end else begin
          // Last life (or none left): clamp at zero rather than wrap.
          lives_s = 2'd0;
          state_s = ST_GAME_OVER;
        end
      end
      default: begin
        cnt_s   = 8'd0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter, score and lives registers.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      score_r <= 8'd0;
      lives_r <= 2'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      score_r <= score_s;
      lives_r <= lives_s;
    end
  end

  // Registered Moore decode of the current state into the drawing/motion flags.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      new_fruit     <= 1'b0;
      move_fruit    <= 1'b0;
      fruit_visible <= 1'b0;
      fruit_sliced  <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      new_fruit     <= (state_r == ST_SPAWN);
      move_fruit    <= (state_r == ST_FLIGHT) || (state_r == ST_SLICED);
      fruit_visible <= (state_r == ST_FLIGHT);
      fruit_sliced  <= (state_r == ST_SLICED);
      game_over     <= (state_r == ST_GAME_OVER);
    end
  end

  assign number_of_fruits_cut = score_r;
  assign lives                = lives_r;

endmodule
